ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Round-robin arbiter that shares the single latency-modelled RAM among NREQ requesters, such as tensor-core load/store units, the fetch path and a DMA/loader. It accepts one read or write per requester, keeps the RAM address and enables stable until the RAM reports ACCESS, and returns a one-cycle done pulse with read data. It also runs a watchdog that aborts transactions that never complete. It sits between the requesters and the RAM's ram_if, driving ramREN, ramWEN, ramaddr and ramstore, and sampling ramload and ramstate.

## Interface
- NREQ, 4: number of requesters, 2..8
- DATA_WIDTH, 32: RAM word width
- ADDR_WIDTH, 10: RAM address width
- TIMEOUT, 64: maximum number of ISSUE cycles before abort; must be greater than RAM LAT+2
- CLK  in  1  clock, rising edge
- RST  in  1  reset; asynchronous, active-high
- req_ren  in  NREQ  per-requester read request
- req_wen  in  NREQ  per-requester write request
- req_addr  in  NREQ×ADDR_WIDTH  per-requester address (packed, requester i at slice i)
- req_wdata  in  NREQ×DATA_WIDTH  per-requester store data
- done  out  NREQ  one-hot, one-cycle completion pulse
- rdata  out  DATA_WIDTH  read data, valid while done is nonzero
- err  out  1  timeout abort, one-cycle pulse coincident with done
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  ADDR_WIDTH  RAM address
- ramstore  out  DATA_WIDTH  RAM write data
- ramload  in  DATA_WIDTH  RAM read data
- ramstate  in  ramstate_t  FREE / BUSY / ACCESS

## Operation
- **Requester contract**
  - A requester raises ren or wen and holds it, with addr and wdata, stable until it sees its done bit.
  - It drops the request on the cycle after done.
  - If ren and wen are both set, the request is treated as a write only.
- **FSM states:** ARB_IDLE, ARB_ISSUE, ARB_RESP.
- **ARB_IDLE**
  - With no pending request (ren|wen for any requester), stay in ARB_IDLE.
  - Otherwise pick the winner by round-robin: the search starts at ptr and wraps modulo NREQ.
  - Latch into holding registers: gnt_id, type (read/write), addr, wdata.
  - Go to ARB_ISSUE.
- **ARB_ISSUE**
  - Drive ramaddr, ramstore and the single enable from the holding registers; these are constant for the whole state.
  - ramstate==ACCESS goes to ARB_RESP.
  - The watchdog counter reaching TIMEOUT-1 without ACCESS sets an abort flag and goes to ARB_RESP.
- **ARB_RESP**
  - Enables are 0.
  - Assert done[gnt_id]=1.
  - rdata is ramload for a completed read, 0 for a write, and 32'hBADBAD truncated to DATA_WIDTH on abort.
  - err=1 on abort.
  - ptr ← (gnt_id+1) mod NREQ.
  - Go to ARB_IDLE.
- **Idle outputs:** outside ARB_ISSUE, ramREN=ramWEN=0 and ramaddr/ramstore hold the last latched values; outside ARB_RESP, done=0, rdata=0 and err=0.
- **Request timing:** requests that change or drop during ARB_ISSUE are ignored, because the holding registers are authoritative. Requests arriving during ISSUE or RESP wait for the next ARB_IDLE.
- **Reset (RST=1)**
  - Immediately: state=ARB_IDLE, ptr=0, watchdog=0, holding registers=0.
  - All outputs go to 0.
  - Reset during ARB_ISSUE drops the transaction without a done pulse. Whether a write was committed is undefined.

## Timing
- The single-shot arbitration cost is one ARB_IDLE cycle, then ARB_ISSUE, then one ARB_RESP cycle.
- Request-to-done latency: 1 (idle) + k (ISSUE cycles, where k includes the ACCESS cycle) + 1 (RESP).
- ramload is registered inside the RAM, so it is sampled in ARB_RESP, one cycle after ACCESS.
- Back-to-back requests: the minimum gap between grants is 3 cycles, and ARB_RESP always deasserts the enables. This forces the RAM to restart its count for the next request, even when the next request is to the same address.
- The watchdog is cleared on entry to ARB_ISSUE and increments every ISSUE cycle. It saturates and never wraps.
- Fairness: any continuously held request is granted within NREQ grants.

## Structure
- Add arbstate_t {ARB_IDLE, ARB_ISSUE, ARB_RESP} to ram_pkg, next to ramstate_t.
- Add the BADBAD abort constant to ram_pkg as RAM_ABORT_WORD.
- Sub-module rr_picker:
  - Combinational; inputs are the pending vector and ptr.
  - Outputs are a valid flag and the winner index.
  - Implemented by rotate, priority-encode, then un-rotate.
- The FSM, watchdog, holding registers and ptr live in ram_arbiter.

## Test plan
- **Single read:** mem[5]=0xCAFE. Req 2 sets ren, addr=5 → ramaddr=5 and ramREN=1 held constant until ACCESS; then done=4'b0100, rdata=0xCAFE for exactly 1 cycle.
- **Write then read:** req 0 writes 0x1234 to addr 9, then req 1 reads addr 9 → first done=0001 with rdata=0; second done=0010 with rdata=0x1234.
- **Round-robin:**
  - All 4 requesters hold reads continuously from reset → grant order 0,1,2,3,0.
  - With ptr=3 and reqs {1,3} pending → grant 3, then 1.
- **Ren+wen together:** requester asserts both → only ramWEN=1; the memory is updated and rdata=0.
- **Timeout:** stub RAM never returns ACCESS, TIMEOUT=8 → after 8 ISSUE cycles, done and err pulse together, rdata=0xBADBAD, and the arbiter returns to ARB_IDLE.
- **Reset mid-ISSUE:** assert RST during ARB_ISSUE → the same cycle shows ramREN=ramWEN=0 and done=0. After release, ptr=0 and the pending request is re-arbitrated and completes normally.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ram_arbiter_pkg
//   Shared types and constants for the RAM arbiter slice.
//   - ramstate_t     : handshake state reported by the latency-modelled RAM
//   - arbstate_t     : arbiter FSM state encoding
//   - RAM_ABORT_WORD : read-data pattern returned when the watchdog aborts
//   - wrap_inc       : modulo-n increment used for the round-robin pointer
// ---------------------------------------------------------------------------
package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_RESP  = 2'd2
    } arbstate_t;

    // Truncated (or zero-extended) to DATA_WIDTH at the point of use.
    localparam logic [31:0] RAM_ABORT_WORD = 32'h00BA_DBAD;

    // (v + 1) mod n without a divider; v is always < n here.
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return ((v + 1) >= n) ? 0 : (v + 1);
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// ---------------------------------------------------------------------------
// ram_arbiter_if
//   Bundles the requester-side bus and the RAM-side bus of the arbiter.
//   Requester side : req_ren, req_wen, req_addr, req_wdata -> done, rdata, err
//   RAM side       : ramREN, ramWEN, ramaddr, ramstore    <- ramload, ramstate
//   Modports:
//   - slave  : the arbiter's view (requests and RAM responses are inputs)
//   - master : the environment's view (requesters plus RAM)
// ---------------------------------------------------------------------------
interface ram_arbiter_if
    import ram_arbiter_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);

    // Requester side; requester i occupies slice i of the packed vectors.
    logic [NREQ-1:0]            req_ren;
    logic [NREQ-1:0]            req_wen;
    logic [NREQ*ADDR_WIDTH-1:0] req_addr;
    logic [NREQ*DATA_WIDTH-1:0] req_wdata;
    logic [NREQ-1:0]            done;
    logic [DATA_WIDTH-1:0]      rdata;
    logic                       err;

    // RAM side.
    logic                       ramREN;
    logic                       ramWEN;
    logic [ADDR_WIDTH-1:0]      ramaddr;
    logic [DATA_WIDTH-1:0]      ramstore;
    logic [DATA_WIDTH-1:0]      ramload;
    ramstate_t                  ramstate;

    modport slave (
        input  req_ren, req_wen, req_addr, req_wdata, ramload, ramstate,
        output done, rdata, err, ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output req_ren, req_wen, req_addr, req_wdata, ramload, ramstate,
        input  done, rdata, err, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/ram_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
//   Combinational round-robin winner selection.
//   i_pending : one bit per requester with an outstanding request
//   i_ptr     : index where the search starts (wraps modulo NREQ)
//   o_valid   : at least one request is pending
//   o_idx     : winning requester index (meaningful only when o_valid)
//   Method: rotate the pending vector right by i_ptr so the search start sits
//   at bit 0, pick the lowest set bit, then add i_ptr back modulo NREQ.
// ---------------------------------------------------------------------------
module rr_picker #(
    parameter int NREQ  = 4,
    parameter int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  i_pending,
    input  logic [PTR_W-1:0] i_ptr,
    output logic             o_valid,
    output logic [PTR_W-1:0] o_idx
);

    logic [2*NREQ-1:0] w_double;
    logic [NREQ-1:0]   w_rot;
    logic [PTR_W-1:0]  w_off;
    logic [PTR_W:0]    w_sum;

    // Doubling the vector turns the rotate into a plain part-select.
    assign w_double = {i_pending, i_pending};

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_rot
            assign w_rot[gi] = w_double[gi + int'(i_ptr)];
        end
    endgenerate

    assign o_valid = |w_rot;

    // Descending scan so the lowest set bit (closest to ptr) wins.
    always_comb begin
        w_off = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = PTR_W'(i);
            end
        end
    end

    // Un-rotate: both terms are < NREQ, so one conditional subtract suffices.
    always_comb begin
        w_sum = {1'b0, i_ptr} + {1'b0, w_off};
        if (w_sum >= (PTR_W + 1)'(NREQ)) begin
            w_sum = w_sum - (PTR_W + 1)'(NREQ);
        end
        o_idx = w_sum[PTR_W-1:0];
    end

endmodule

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
//   Shares one latency-modelled RAM among NREQ requesters with round-robin
//   fairness. One transaction at a time: IDLE (arbitrate and latch) ->
//   ISSUE (hold the RAM address/enable until ACCESS or watchdog expiry) ->
//   RESP (one-cycle done pulse with read data, enables dropped).
//   Ports:
//   - CLK : clock, rising edge
//   - RST : asynchronous active-high reset
//   - bus : ram_arbiter_if.slave (requester bus and RAM bus)
//   Parameters: NREQ (2..8), DATA_WIDTH, ADDR_WIDTH, TIMEOUT (> RAM LAT+2).
// ---------------------------------------------------------------------------
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int TIMEOUT    = 64
) (
    input  logic          CLK,
    input  logic          RST,
    ram_arbiter_if.slave  bus
);

    localparam int PTR_W = $clog2(NREQ);
    localparam int WD_W  = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    // State and holding registers.
    arbstate_t              r_state;
    logic [PTR_W-1:0]       r_ptr;
    logic [PTR_W-1:0]       r_gnt;
    logic                   r_is_write;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic [WD_W-1:0]        r_wdog;
    logic                   r_abort;

    // Combinational.
    arbstate_t              w_state_next;
    logic                   w_load;
    logic                   w_access;
    logic                   w_wdog_expired;
    logic [NREQ-1:0]        w_pending;
    logic                   w_pick_valid;
    logic [PTR_W-1:0]       w_pick;
    logic [ADDR_WIDTH-1:0]  w_req_addr  [NREQ];
    logic [DATA_WIDTH-1:0]  w_req_wdata [NREQ];

    // Split the packed request buses into per-requester views.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_req_addr[gi]  = bus.req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_req_wdata[gi] = bus.req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign w_pending      = bus.req_ren | bus.req_wen;
    assign w_access       = (bus.ramstate == ACCESS);
    assign w_wdog_expired = (r_wdog == WD_LAST);

    rr_picker #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .i_pending (w_pending),
        .i_ptr     (r_ptr),
        .o_valid   (w_pick_valid),
        .o_idx     (w_pick)
    );

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (w_pick_valid) begin
                    w_load       = 1'b1;
                    w_state_next = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                // ACCESS takes precedence over a watchdog expiring that cycle.
                if (w_access || w_wdog_expired) begin
                    w_state_next = ARB_RESP;
                end
            end
            ARB_RESP: begin
                w_state_next = ARB_IDLE;
            end
            default: begin
                w_state_next = ARB_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs: decoded from registered state only, so reset clears them
    // immediately.
    // -----------------------------------------------------------------------
    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = r_addr;
        bus.ramstore = r_wdata;
        bus.done     = '0;
        bus.rdata    = '0;
        bus.err      = 1'b0;
        case (r_state)
            ARB_ISSUE: begin
                bus.ramREN = ~r_is_write;
                bus.ramWEN = r_is_write;
            end
            ARB_RESP: begin
                bus.done[r_gnt] = 1'b1;
                bus.err         = r_abort;
                if (r_abort) begin
                    bus.rdata = DATA_WIDTH'(RAM_ABORT_WORD);
                end else if (!r_is_write) begin
                    // RAM read data is registered, so it is valid one cycle
                    // after ACCESS, i.e. here.
                    bus.rdata = bus.ramload;
                end
            end
            default: begin
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State, holding registers, watchdog and round-robin pointer
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= ARB_IDLE;
            r_ptr      <= '0;
            r_gnt      <= '0;
            r_is_write <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wdog     <= '0;
            r_abort    <= 1'b0;
        end else begin
            r_state <= w_state_next;

            if (w_load) begin
                r_gnt      <= w_pick;
                // ren together with wen is treated as a write.
                r_is_write <= bus.req_wen[w_pick];
                r_addr     <= w_req_addr[w_pick];
                r_wdata    <= w_req_wdata[w_pick];
                r_wdog     <= '0;
                r_abort    <= 1'b0;
            end

            if (r_state == ARB_ISSUE) begin
                if (w_access) begin
                    r_abort <= 1'b0;
                end else if (w_wdog_expired) begin
                    r_abort <= 1'b1;
                end else begin
                    // Saturating: the expired branch above stops the count.
                    r_wdog <= r_wdog + 1'b1;
                end
            end

            if (r_state == ARB_RESP) begin
                r_ptr <= PTR_W'(wrap_inc(32'(r_gnt), NREQ));
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_arbiter
//   Drives batches of simultaneous requests into ram_arbiter, backed by a
//   latency-modelled RAM. A reference model predicts the completion order
//   (round-robin over the held requests) and the response of each
//   transaction; a monitor compares each done pulse against the queue.
// ---------------------------------------------------------------------------
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int AW   = 10;
    localparam int TO   = 8;
    localparam int MEMN = 1 << AW;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    ram_arbiter_if #(.NREQ(NREQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    ram_arbiter #(
        .NREQ       (NREQ),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .TIMEOUT    (TO)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    endtask

    // ---------------- RAM model ----------------
    logic [DW-1:0] ram_mem [MEMN];
    logic [DW-1:0] ram_q;
    int            ram_cnt;
    int            ram_lat = 1;
    bit            ram_stuck = 1'b0;

    assign bus.ramload = ram_q;

    always_comb begin
        bus.ramstate = FREE;
        if (bus.ramREN || bus.ramWEN) begin
            if (!ram_stuck && ram_cnt == ram_lat) bus.ramstate = ACCESS;
            else                                  bus.ramstate = BUSY;
        end
    end

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            ram_cnt <= 0;
        end else if (bus.ramREN || bus.ramWEN) begin
            if (!ram_stuck && ram_cnt == ram_lat) begin
                if (bus.ramWEN) ram_mem[bus.ramaddr] <= bus.ramstore;
                ram_q   <= ram_mem[bus.ramaddr];
                ram_cnt <= 0;
            end else begin
                ram_cnt <= ram_cnt + 1;
            end
        end else begin
            ram_cnt <= 0;
        end
    end

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        int            id;
        bit            is_write;
        logic [AW-1:0] addr;
        logic [DW-1:0] rdata;
        bit            err;
        int            k;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] ref_mem [MEMN];
    int            m_ptr = 0;

    logic [NREQ-1:0] b_ren, b_wen;
    logic [AW-1:0]   b_addr [NREQ];
    logic [DW-1:0]   b_data [NREQ];

    // Every held request completes exactly once; each grant goes to the
    // first pending requester at or after the pointer, which then moves past it.
    task automatic model_batch(input logic [NREQ-1:0] mask);
        logic [NREQ-1:0] left;
        exp_t e;
        left = mask;
        while (left != 0) begin
            int c;
            c = -1;
            for (int s = 0; s < NREQ; s++) begin
                if (c < 0 && left[(m_ptr + s) % NREQ]) c = (m_ptr + s) % NREQ;
            end
            left[c]    = 1'b0;
            e.id       = c;
            e.is_write = b_wen[c];
            e.addr     = b_addr[c];
            if (ram_stuck) begin
                e.rdata = DW'(32'h00BADBAD);
                e.err   = 1'b1;
                e.k     = TO;
            end else begin
                e.err = 1'b0;
                e.k   = ram_lat + 1;
                if (b_wen[c]) begin
                    ref_mem[b_addr[c]] = b_data[c];
                    e.rdata = '0;
                end else begin
                    e.rdata = ref_mem[b_addr[c]];
                end
            end
            exp_q.push_back(e);
            m_ptr = (c + 1) % NREQ;
        end
    endtask

    task automatic apply_reqs(input logic [NREQ-1:0] mask);
        @(negedge CLK);
        bus.req_ren = b_ren & mask;
        bus.req_wen = b_wen & mask;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_addr[i*AW +: AW]  = b_addr[i];
            bus.req_wdata[i*DW +: DW] = b_data[i];
        end
    endtask

    // Each requester drops its request once it has seen its done bit.
    task automatic wait_done(input logic [NREQ-1:0] mask);
        logic [NREQ-1:0] outst;
        int cyc;
        outst = mask;
        cyc   = 0;
        while (outst != 0 && cyc < 400) begin
            @(negedge CLK);
            cyc++;
            outst       = outst & ~bus.done;
            bus.req_ren = bus.req_ren & ~bus.done;
            bus.req_wen = bus.req_wen & ~bus.done;
        end
        if (outst != 0) begin
            chk("batch_timeout", 64'(outst), 64'(0));
            bus.req_ren = '0;
            bus.req_wen = '0;
        end
        @(negedge CLK);
    endtask

    task automatic run_batch(input logic [NREQ-1:0] mask);
        model_batch(mask);
        apply_reqs(mask);
        wait_done(mask);
    endtask

    task automatic set_req(input int i, input bit ren, input bit wen,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        b_ren[i]  = ren;
        b_wen[i]  = wen;
        b_addr[i] = a;
        b_data[i] = d;
    endtask

    // ---------------- monitor ----------------
    int            mon_issue;
    bit            mon_ren, mon_wen, mon_first, mon_stable;
    logic [AW-1:0] mon_addr;

    initial begin
        mon_issue = 0; mon_ren = 0; mon_wen = 0; mon_first = 1; mon_stable = 1; mon_addr = '0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                mon_issue = 0; mon_ren = 0; mon_wen = 0; mon_first = 1; mon_stable = 1;
            end else begin
                if (bus.ramREN || bus.ramWEN) begin
                    mon_issue++;
                    if (bus.ramREN) mon_ren = 1;
                    if (bus.ramWEN) mon_wen = 1;
                    if (mon_first) begin
                        mon_addr  = bus.ramaddr;
                        mon_first = 0;
                    end else if (bus.ramaddr != mon_addr) begin
                        mon_stable = 0;
                    end
                end
                if (bus.done != 0) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 64'(bus.done), 64'(0));
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        $display("txn id=%0d %s addr=%0h rdata=%0h err=%0b issue_cycles=%0d",
                                 e.id, e.is_write ? "WR" : "RD", e.addr, bus.rdata, bus.err, mon_issue);
                        chk("done",        64'(bus.done),  64'(NREQ'(1) << e.id));
                        chk("rdata",       64'(bus.rdata), 64'(e.rdata));
                        chk("err",         64'(bus.err),   64'(e.err));
                        chk("issue_len",   64'(mon_issue), 64'(e.k));
                        chk("ren_used",    64'(mon_ren),   64'(!e.is_write));
                        chk("wen_used",    64'(mon_wen),   64'(e.is_write));
                        chk("ramaddr",     64'(mon_addr),  64'(e.addr));
                        chk("addr_stable", 64'(mon_stable), 64'(1));
                    end
                    mon_issue = 0; mon_ren = 0; mon_wen = 0; mon_first = 1; mon_stable = 1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [NREQ-1:0] m;
        int cyc;

        bus.req_ren = '0; bus.req_wen = '0; bus.req_addr = '0; bus.req_wdata = '0;
        b_ren = '0; b_wen = '0;
        for (int i = 0; i < NREQ; i++) begin b_addr[i] = '0; b_data[i] = '0; end
        for (int a = 0; a < MEMN; a++) begin
            logic [DW-1:0] v;
            v = $urandom;
            if (a == 5) v = 32'h0000CAFE;
            ram_mem[a] <= v;
            ref_mem[a] = v;
        end

        RST = 1'b1;
        repeat (3) @(negedge CLK);
        chk("rst_done",   64'(bus.done),    64'(0));
        chk("rst_rdata",  64'(bus.rdata),   64'(0));
        chk("rst_err",    64'(bus.err),     64'(0));
        chk("rst_ren",    64'(bus.ramREN),  64'(0));
        chk("rst_wen",    64'(bus.ramWEN),  64'(0));
        chk("rst_addr",   64'(bus.ramaddr), 64'(0));
        chk("rst_store",  64'(bus.ramstore), 64'(0));
        RST = 1'b0;
        @(negedge CLK);

        // Single read of 0xCAFE by requester 2.
        ram_lat = 2;
        set_req(2, 1, 0, 10'd5, '0);
        run_batch(4'b0100);

        // Write then read back.
        set_req(0, 0, 1, 10'd9, 32'h1234);
        run_batch(4'b0001);
        set_req(1, 1, 0, 10'd9, '0);
        run_batch(4'b0010);

        // Move ptr to 3, then {1,3} pending -> 3 then 1.
        set_req(2, 1, 0, 10'd5, '0);
        run_batch(4'b0100);
        set_req(1, 1, 0, 10'd9, '0);
        set_req(3, 1, 0, 10'd5, '0);
        run_batch(4'b1010);

        // All four reading at once.
        ram_lat = 0;
        for (int i = 0; i < NREQ; i++) set_req(i, 1, 0, AW'(i + 3), '0);
        run_batch(4'b1111);

        // ren and wen together behave as a write.
        ram_lat = 3;
        set_req(1, 1, 1, 10'd7, 32'h55AA);
        run_batch(4'b0010);
        set_req(1, 1, 0, 10'd7, '0);
        run_batch(4'b0010);
        chk("mem_write_both", 64'(ram_mem[7]), 64'(32'h55AA));

        // RAM that never answers: watchdog abort.
        ram_stuck = 1'b1;
        set_req(3, 0, 1, 10'd20, 32'hDEAD);
        run_batch(4'b1000);
        ram_stuck = 1'b0;

        // Reset in the middle of ISSUE. ptr is set to 2 first so that the
        // interrupted grant goes to requester 3; after reset ptr=0 picks 0.
        ram_lat = 3;
        set_req(1, 1, 0, 10'd5, '0);
        run_batch(4'b0010);
        set_req(0, 1, 0, 10'd5, '0);
        set_req(3, 1, 0, 10'd9, '0);
        apply_reqs(4'b1001);
        cyc = 0;
        while (!(bus.ramREN || bus.ramWEN) && cyc < 50) begin
            @(negedge CLK);
            cyc++;
        end
        chk("reach_issue", 64'(bus.ramREN), 64'(1));
        RST = 1'b1;
        #1;
        chk("midrst_ren",  64'(bus.ramREN), 64'(0));
        chk("midrst_wen",  64'(bus.ramWEN), 64'(0));
        chk("midrst_done", 64'(bus.done),   64'(0));
        @(negedge CLK);
        RST = 1'b0;
        m_ptr = 0;
        model_batch(4'b1001);
        wait_done(4'b1001);

        // Randomized batches.
        for (int t = 0; t < 50; t++) begin
            ram_lat = $urandom_range(0, 3);
            m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) begin
                int op;
                op = $urandom_range(0, 2);
                set_req(i, op != 1, op != 0, AW'($urandom_range(0, 15)), $urandom);
            end
            run_batch(m);
        end

        repeat (4) @(negedge CLK);
        chk("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "simulation time limit");
    end

endmodule
